// File: rtl/dmac_uni_param.sv
// dmac_uni_param -- parameterised unary (stochastic) dot-product engine.
//
// Each lane compares its operands against low-discrepancy (van der Corput)
// sequences to form a product bit. The lane bits are then combined by an OR
// adder (MODE 0) or a rotating MUX adder (MODE 1, scaled by 1/N). One run
// lasts 2^(2*BW) cycles and emits one qualified output bit per cycle.
//
// Parameters:
//   N    - number of product lanes (power of two, >= 2)
//   BW   - operand width in bits (2..10)
//   MODE - 0 = OR adder (nonscaled), 1 = MUX adder (scaled by 1/N)
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   iA, iB        - N x BW unsigned operands, lane i at [i*BW +: BW]
//   loadA, loadB  - capture iA / iB (accepted only while idle)
//   start         - one-cycle run request (ignored while busy)
//   busy          - high in RUN and FLUSH
//   oC, oValid    - output bitstream and its qualifier
//   done          - one-cycle pulse on the final oValid cycle
//   acc           - count of ones in oC over the run; this port exists only
//                   when the macro DMAC_UNI_ACC_EN is defined
//
// Handshake: oC is meaningful only in cycles where oValid is high; oValid is
// high for exactly 2^(2*BW) consecutive cycles per run and there is no
// backpressure. oC is forced low whenever oValid is low.

module dmac_uni_param #(
    parameter int N    = 16,
    parameter int BW   = 8,
    parameter int MODE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*BW-1:0] iA,
    input  logic [N*BW-1:0] iB,
    input  logic            loadA,
    input  logic            loadB,
    input  logic            start,
    output logic            busy,
    output logic            oC,
    output logic            oValid,
    output logic            done
`ifdef DMAC_UNI_ACC_EN
    ,
    output logic [2*BW:0]   acc
`endif
);

    localparam int LN = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t          state;
    logic [BW-1:0]   cntA;
    logic [BW-1:0]   cntB;
    logic [N*BW-1:0] regA;
    logic [N*BW-1:0] regB;

    logic [BW-1:0]   seqA;
    logic [BW-1:0]   seqB;
    logic [N-1:0]    p;
    logic            s;
    logic            lastK;

    // Bit reversal of the counters gives the Sobol dimension-1 sequence.
    for (genvar j = 0; j < BW; j++) begin : g_rev
        assign seqA[j] = cntA[BW-1-j];
        assign seqB[j] = cntB[BW-1-j];
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign p[i] = (regA[i*BW +: BW] > seqA) && (regB[i*BW +: BW] > seqB);
    end

    if (MODE == 0) begin : g_or_add
        assign s = |p;
    end else begin : g_mux_add
        // The selected lane changes once per cntA sweep, so every lane gets
        // an equal share of full seqA sweeps over the run.
        logic [LN-1:0] sel;
        for (genvar j = 0; j < LN; j++) begin : g_sel
            assign sel[j] = cntB[LN-1-j];
        end
        assign s = p[sel];
    end

    assign lastK = (&cntA) && (&cntB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cntA   <= '0;
            cntB   <= '0;
            regA   <= '0;
            regB   <= '0;
            busy   <= 1'b0;
            oC     <= 1'b0;
            oValid <= 1'b0;
            done   <= 1'b0;
        end else begin
            oC     <= 1'b0;
            oValid <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    // Loads land on the same edge as start, so a combined
                    // load+start runs on the new operands.
                    if (loadA) regA <= iA;
                    if (loadB) regB <= iB;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        cntA  <= '0;
                        cntB  <= '0;
                    end
                end
                RUN: begin
                    // Output of index k appears one cycle later, so the last
                    // product bit (and done) lands in the FLUSH cycle.
                    oValid <= 1'b1;
                    oC     <= s;
                    cntA   <= cntA + 1'b1;
                    if (&cntA) cntB <= cntB + 1'b1;
                    if (lastK) begin
                        state <= FLUSH;
                        done  <= 1'b1;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMAC_UNI_ACC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (state == IDLE && start) begin
            acc <= '0;
        end else if (oValid && oC) begin
            acc <= acc + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dmac_uni_param.sv
// Bench for dmac_uni_param: two instances (OR adder and MUX adder) with
// BW=4, N=4 run in lockstep on shared inputs. Expected bitstreams come from
// a reference model built directly from the sequence/compare/adder rules.

module tb_dmac_uni_param;

    localparam int N   = 4;
    localparam int BW  = 4;
    localparam int LN  = 2;
    localparam int LEN = 1 << (2*BW);

    logic            clk;
    logic            rst_n;
    logic [N*BW-1:0] iA;
    logic [N*BW-1:0] iB;
    logic            loadA;
    logic            loadB;
    logic            start;
    logic            busy0, oC0, oValid0, done0;
    logic            busy1, oC1, oValid1, done1;
`ifdef DMAC_UNI_ACC_EN
    logic [2*BW:0]   acc0;
    logic [2*BW:0]   acc1;
`endif

    dmac_uni_param #(.N(N), .BW(BW), .MODE(0)) u_or (
        .clk(clk), .rst_n(rst_n), .iA(iA), .iB(iB),
        .loadA(loadA), .loadB(loadB), .start(start),
        .busy(busy0), .oC(oC0), .oValid(oValid0), .done(done0)
`ifdef DMAC_UNI_ACC_EN
        , .acc(acc0)
`endif
    );

    dmac_uni_param #(.N(N), .BW(BW), .MODE(1)) u_mux (
        .clk(clk), .rst_n(rst_n), .iA(iA), .iB(iB),
        .loadA(loadA), .loadB(loadB), .start(start),
        .busy(busy1), .oC(oC1), .oValid(oValid1), .done(done1)
`ifdef DMAC_UNI_ACC_EN
        , .acc(acc1)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    logic [1:0]  exp_q[$];     // bit0 = OR instance, bit1 = MUX instance
    int          cnt0_q[$];
    int          cnt1_q[$];
    int          mA[N];
    int          mB[N];
    int          last0;
    int          last1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int rev(input int x, input int w);
        int r = 0;
        for (int j = 0; j < w; j++)
            if ((x >> j) & 1) r = r | (1 << (w-1-j));
        return r;
    endfunction

    function automatic logic model_bit(input int k, input int mode);
        int ca = k % (1 << BW);
        int cb = k / (1 << BW);
        int sa = rev(ca, BW);
        int sb = rev(cb, BW);
        int sel;
        if (mode == 0) begin
            for (int i = 0; i < N; i++)
                if (mA[i] > sa && mB[i] > sb) return 1'b1;
            return 1'b0;
        end
        sel = rev(cb % N, LN);
        return (mA[sel] > sa && mB[sel] > sb);
    endfunction

    // Queue a full expected run; a non-negative want overrides the model sum
    // with a value known in closed form.
    task automatic push_run(input int want0, input int want1);
        int s0 = 0;
        int s1 = 0;
        for (int k = 0; k < LEN; k++) begin
            logic b0, b1;
            b0 = model_bit(k, 0);
            b1 = model_bit(k, 1);
            exp_q.push_back({b1, b0});
            s0 += int'(b0);
            s1 += int'(b1);
        end
        last0 = (want0 >= 0) ? want0 : s0;
        last1 = (want1 >= 0) ? want1 : s1;
        cnt0_q.push_back(last0);
        cnt1_q.push_back(last1);
    endtask

    // ---------------- monitor ----------------
    int         ones0;
    int         ones1;
    logic [1:0] mon_e;
    logic       mon_last;

    always @(negedge clk) begin
        if (!rst_n) begin
            ones0 = 0;
            ones1 = 0;
        end else if (oValid0 === 1'b1 || oValid1 === 1'b1) begin
            check("oValid_lockstep", oValid1, oValid0);
            if (exp_q.size() == 0) begin
                check("oValid_unexpected", oValid0, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("oC_or", oC0, mon_e[0]);
                check("oC_mux", oC1, mon_e[1]);
                if (oC0 === 1'b1) ones0++;
                if (oC1 === 1'b1) ones1++;
                mon_last = (exp_q.size() == 0);
                check("done_or", done0, mon_last);
                check("done_mux", done1, mon_last);
                if (mon_last && cnt0_q.size() > 0 && cnt1_q.size() > 0) begin
                    check("ones_or", ones0, cnt0_q.pop_front());
                    check("ones_mux", ones1, cnt1_q.pop_front());
                    ones0 = 0;
                    ones1 = 0;
                end
            end
        end else begin
            check("oC_or_quiet", oC0, 0);
            check("oC_mux_quiet", oC1, 0);
            check("done_or_quiet", done0, 0);
            check("done_mux_quiet", done1, 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*BW-1:0] lanes(input int v0, input int v1, input int v2, input int v3);
        logic [N*BW-1:0] r;
        r = '0;
        r[0*BW +: BW] = v0[BW-1:0];
        r[1*BW +: BW] = v1[BW-1:0];
        r[2*BW +: BW] = v2[BW-1:0];
        r[3*BW +: BW] = v3[BW-1:0];
        return r;
    endfunction

    task automatic begin_run(input logic [N*BW-1:0] a, input logic [N*BW-1:0] b,
                             input logic doA, input logic doB, input int want0, input int want1);
        iA    = a;
        iB    = b;
        loadA = doA;
        loadB = doB;
        start = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (doA) mA[i] = int'(a[i*BW +: BW]);
            if (doB) mB[i] = int'(b[i*BW +: BW]);
        end
        push_run(want0, want1);
        tick();
        loadA = 1'b0;
        loadB = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done0 !== 1'b1 && n < LEN + 20) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", done0, 1);
        if (done0 !== 1'b1) begin
            exp_q.delete();
            cnt0_q.delete();
            cnt1_q.delete();
        end
        @(negedge clk);
        check("busy_or_after_done", busy0, 0);
        check("busy_mux_after_done", busy1, 0);
`ifdef DMAC_UNI_ACC_EN
        check("acc_or", acc0, last0);
        check("acc_mux", acc1, last1);
`endif
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_busy_or"},   busy0,   0);
        check({tag, "_oC_or"},     oC0,     0);
        check({tag, "_oValid_or"}, oValid0, 0);
        check({tag, "_done_or"},   done0,   0);
        check({tag, "_busy_mux"},  busy1,   0);
        check({tag, "_oValid_mux"}, oValid1, 0);
`ifdef DMAC_UNI_ACC_EN
        check({tag, "_acc_or"},    acc0,    0);
        check({tag, "_acc_mux"},   acc1,    0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        iA    = '0;
        iB    = '0;
        loadA = 1'b0;
        loadB = 1'b0;
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            mA[i] = 0;
            mB[i] = 0;
        end
        repeat (2) tick();
        check_all_low("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Single nonzero lane: exact product a*b from the OR adder.
        begin_run(lanes(8, 0, 0, 0), lanes(8, 0, 0, 0), 1'b1, 1'b1, 64, -1);
        wait_done();

        // Full-scale operands on every lane.
        begin_run(lanes(15, 15, 15, 15), lanes(15, 15, 15, 15), 1'b1, 1'b1, 225, 225);
        wait_done();

        // Zero A operands: the stream must stay silent.
        begin_run(lanes(0, 0, 0, 0), lanes(15, 15, 15, 15), 1'b1, 1'b1, 0, 0);
        wait_done();

        // Lane 2 only, a=15, b=1.
        begin_run(lanes(0, 0, 15, 0), lanes(0, 0, 1, 0), 1'b1, 1'b1, 15, -1);
        wait_done();

        // Load only A with start; B keeps its previous value.
        begin_run(lanes(3, 7, 15, 11), '0, 1'b1, 1'b0, -1, -1);
        wait_done();

        // Random operands.
        for (int r = 0; r < 8; r++) begin
            begin_run(lanes($urandom_range(0, 15), $urandom_range(0, 15),
                            $urandom_range(0, 15), $urandom_range(0, 15)),
                      lanes($urandom_range(0, 15), $urandom_range(0, 15),
                            $urandom_range(0, 15), $urandom_range(0, 15)),
                      1'b1, 1'b1, -1, -1);
            if (r == 3) begin
                // Mid-run load and a second start must not disturb the run.
                repeat ($urandom_range(20, 200)) tick();
                iA    = lanes(1, 2, 3, 4);
                iB    = lanes(9, 9, 9, 9);
                loadA = 1'b1;
                loadB = 1'b1;
                start = 1'b1;
                tick();
                loadA = 1'b0;
                loadB = 1'b0;
                start = 1'b0;
            end
            wait_done();
        end

        // Reset mid-run: everything drops at once, no done for the aborted run.
        begin_run(lanes(15, 9, 4, 12), lanes(13, 2, 15, 6), 1'b1, 1'b1, -1, -1);
        repeat (100) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_low("midrun_reset");
        exp_q.delete();
        cnt0_q.delete();
        cnt1_q.delete();
        for (int i = 0; i < N; i++) begin
            mA[i] = 0;
            mB[i] = 0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Operands were cleared by reset: a run without loads yields nothing.
        begin_run('0, '0, 1'b0, 1'b0, 0, 0);
        wait_done();

        // A full run after reset.
        begin_run(lanes(15, 15, 15, 15), lanes(15, 15, 15, 15), 1'b1, 1'b1, 225, 225);
        wait_done();

        repeat (4) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmac_uni_param.md
DMAC_UNI_PARAM -- requirements
Module: dmac_uni_param

Interface
REQ-001 SHALL have parameter N, default 16, meaning the number of product lanes (a power of two, at least 2).
REQ-002 SHALL have parameter BW, default 8, meaning the operand width in bits (range 2 to 10).
REQ-003 SHALL have parameter MODE, default 0, meaning the adder type: 0 = OR adder (nonscaled), 1 = MUX adder (scaled by 1/N).
REQ-004 SHALL have port clk, input, 1 bit: the clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port iA, input, N x BW bits: the per-lane unsigned operand A.
REQ-007 SHALL have port iB, input, N x BW bits: the per-lane unsigned operand B.
REQ-008 SHALL have port loadA, input, 1 bit: captures all iA lanes into internal registers.
REQ-009 SHALL have port loadB, input, 1 bit: captures all iB lanes into internal registers.
REQ-010 SHALL have port start, input, 1 bit: a one-cycle request to begin a run.
REQ-011 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-012 SHALL have port oC, output, 1 bit: the unary output bitstream.
REQ-013 SHALL have port oValid, output, 1 bit: qualifies oC.
REQ-014 SHALL have port done, output, 1 bit: a one-cycle pulse on the final oValid cycle.
REQ-015 SHALL have port acc, output, 2*BW+1 bits: the count of ones in oC over a run; present only when DMAC_UNI_ACC_EN is defined.

Function
REQ-016 SHALL use a state machine with three states: IDLE, RUN and FLUSH.
REQ-017 SHALL go from IDLE to RUN on the cycle after start is sampled high; start is ignored in RUN and FLUSH.
REQ-018 SHALL stay in RUN for exactly 2^(2*BW) cycles, indexed by k = 0 .. 2^(2*BW)-1, then go to FLUSH for 1 cycle, then return to IDLE.
REQ-019 SHALL use counter cntA = k mod 2^BW and counter cntB = floor(k / 2^BW); cntB advances only on the cycle cntA wraps from all-ones to 0.
REQ-020 SHALL use sequences seqA = bit-reverse(cntA) and seqB = bit-reverse(cntB), i.e. the Sobol dimension-1 (van der Corput) order.
REQ-021 SHALL compute lane product bit p[i] = (a[i] > seqA) AND (b[i] > seqB), using unsigned compares.
REQ-022 SHALL, in MODE 0, form the sum bit s = OR of p[0..N-1].
REQ-023 SHALL, in MODE 1, form s = p[sel], where sel = bit-reverse of the low log2(N) bits of cntB.
REQ-024 SHALL register oC as s with 1-cycle latency: oValid is high in the cycles from RUN cycle 1 through the FLUSH cycle, which is exactly 2^(2*BW) cycles.
REQ-025 SHALL assert busy in RUN and FLUSH; done is high only in the FLUSH cycle.
REQ-026 SHALL update the operand registers on loadA/loadB only in IDLE; loads during busy are ignored, so operands stay frozen for the whole run.
REQ-027 SHALL, when start and a load occur in the same IDLE cycle, capture the load first, so the run uses the new operands.
REQ-028 SHALL hold oC low whenever oValid is low.
REQ-029 SHALL make the result exact: in MODE 0 with a single nonzero lane, the ones count equals a*b.

Reset
REQ-030 SHALL, on rst_n low at any time (including mid-run), immediately force: state IDLE; all counters 0; operand registers 0; busy, oC, oValid and done all 0; acc 0.
REQ-031 SHALL not produce a done pulse for a run aborted by reset.

Configuration
REQ-032 SHALL, with DMAC_UNI_ACC_EN defined, provide acc: cleared on the cycle start is accepted, incremented on each cycle where oValid AND oC is high, and held after done until the next start.
REQ-033 SHALL, without DMAC_UNI_ACC_EN defined, have no acc port and no counter logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover: BW=8, N=16, MODE 0; lane0 a=128, b=128, other lanes 0; start -> exactly 65536 oValid cycles, one done pulse, acc = 16384.
REQ-035 SHALL cover: BW=8, MODE 0, all lanes a=255, b=255 -> acc = 65025; busy low the cycle after done.
REQ-036 SHALL cover: BW=8, N=16, MODE 1, all lanes a=255, b=255 -> acc = 65025; all lanes a=0 -> acc = 0, oC never high.
REQ-037 SHALL cover: loadA with new values mid-run, plus a second start mid-run -> the run result is unchanged and there is only one done pulse.
REQ-038 SHALL cover: rst_n asserted at k=1000 -> all outputs 0 immediately and no done pulse; a following start yields a full, correct run.
REQ-039 SHALL cover: BW=4, N=4, MODE 0; lane2 a=15, b=1 -> 256 valid cycles, acc = 15.
